ram_readback_checker: RTL and testbench

Read-back verifier for the 16 x 8 lab RAM. Once the loader has filled the RAM with a selected pattern, this block sweeps every address and compares each word against the expected value for the same `mode` encoding. It reports pass/fail, the error count, and the first failing address and data to the seven-segment and LED logic. It owns the RAM address and write-enable while busy and never writes.

---
 rtl/ram_readback_checker_if.sv | 31 +++
 rtl/ram_readback_checker.sv | 144 ++++++++++++++
 tb/tb_ram_readback_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ram_readback_checker_if.sv
// Bus bundle between the RAM read-back checker and its RAM / stimulus / display side.
interface ram_readback_checker_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] pattern;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_wren;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_WIDTH:0]   error_count;
  logic                  fail_valid;
  logic [ADDR_WIDTH-1:0] first_fail_address;
  logic [DATA_WIDTH-1:0] first_fail_data;

  modport master (
    output start, mode, pattern, ram_q,
    input  ram_address, ram_wren, busy, done, pass, error_count,
           fail_valid, first_fail_address, first_fail_data
  );

  modport slave (
    input  start, mode, pattern, ram_q,
    output ram_address, ram_wren, busy, done, pass, error_count,
           fail_valid, first_fail_address, first_fail_data
  );
endinterface

// File: rtl/ram_readback_checker.sv
// Sweeps every RAM address, compares each word to the selected pattern and
// reports pass/fail, mismatch count and the first failing address/data.
module ram_readback_checker #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              clear,
  ram_readback_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] pattern_q;
  logic [ADDR_WIDTH:0]   err_cnt;
  logic                  pass_q;
  logic                  fv_q;
  logic [ADDR_WIDTH-1:0] ffa_q;
  logic [DATA_WIDTH-1:0] ffd_q;

  // Tag pipeline tracks which address each ram_q word belongs to.
  logic [READ_LATENCY-1:0] pv;
  logic [ADDR_WIDTH-1:0]   pa [READ_LATENCY];

  logic                  issue;
  logic                  busy_c;
  logic                  done_c;
  logic                  tag_valid;
  logic [ADDR_WIDTH-1:0] tag;
  logic [DATA_WIDTH-1:0] expected;
  logic                  mismatch;
  logic                  final_cmp;

  assign tag       = pa[READ_LATENCY-1];
  assign tag_valid = pv[READ_LATENCY-1];
  assign final_cmp = tag_valid && (&tag);

  always_comb begin
    expected = '0;
    case (mode_q)
      2'b00:   expected = pattern_q;
      2'b01:   expected = '0;
      2'b10:   expected = '1;
      default: expected = DATA_WIDTH'({~tag, tag});
    endcase
  end

  assign mismatch = tag_valid && (bus.ram_q != expected);

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = ISSUE;
      ISSUE:   if (&addr)     next_state = DRAIN;
      DRAIN:   if (final_cmp) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    issue  = 1'b0;
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      ISSUE: begin
        issue  = 1'b1;
        busy_c = 1'b1;
      end
      DRAIN:   busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      pv <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pa[i] <= '0;
    end else begin
      pv[0] <= issue;
      pa[0] <= addr;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      addr      <= '0;
      mode_q    <= '0;
      pattern_q <= '0;
      err_cnt   <= '0;
      pass_q    <= 1'b0;
      fv_q      <= 1'b0;
      ffa_q     <= '0;
      ffd_q     <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        mode_q    <= bus.mode;
        pattern_q <= bus.pattern;
        addr      <= '0;
        err_cnt   <= '0;
        fv_q      <= 1'b0;
        pass_q    <= 1'b0;
      end else if (issue && !(&addr)) begin
        addr <= addr + ADDR_WIDTH'(1);
      end
      if (mismatch) begin
        err_cnt <= err_cnt + (ADDR_WIDTH+1)'(1);
        if (!fv_q) begin
          fv_q  <= 1'b1;
          ffa_q <= tag;
          ffd_q <= bus.ram_q;
        end
      end
      // Final compare may itself mismatch, so fold it into the verdict.
      if (final_cmp) pass_q <= (err_cnt == '0) && !mismatch;
    end
  end

  assign bus.ram_address        = addr;
  assign bus.ram_wren           = 1'b0;
  assign bus.busy               = busy_c;
  assign bus.done               = done_c;
  assign bus.pass               = pass_q;
  assign bus.error_count        = err_cnt;
  assign bus.fail_valid         = fv_q;
  assign bus.first_fail_address = ffa_q;
  assign bus.first_fail_data    = ffd_q;

endmodule

// File: tb/tb_ram_readback_checker.sv
// Scoreboard bench: each accepted start queues the expected sweep result,
// a monitor pops and checks it when done pulses.
module tb_ram_readback_checker;
  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    int err;
    int pass;
    int fv;
    int ffa;
    int ffd;
    int done_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  ram_readback_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_readback_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  logic [DW-1:0] mem [16];
  always @(posedge clock) bus.ram_q <= mem[bus.ram_address];

  int   cyc = 0;
  always @(posedge clock) cyc++;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   wren_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.ram_wren !== 1'b0) wren_seen = 1'b1;
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("busy_in_done", 32'(bus.busy), 32'(0));
          chk("pass", 32'(bus.pass), 32'(e.pass));
          chk("error_count", 32'(bus.error_count), 32'(e.err));
          chk("fail_valid", 32'(bus.fail_valid), 32'(e.fv));
          chk("first_fail_address", 32'(bus.first_fail_address), 32'(e.ffa));
          chk("first_fail_data", 32'(bus.first_fail_data), 32'(e.ffd));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_address"}, 32'(bus.ram_address), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(0));
    chk({tag, "_error_count"}, 32'(bus.error_count), 32'(0));
    chk({tag, "_fail_valid"}, 32'(bus.fail_valid), 32'(0));
    chk({tag, "_ffa"}, 32'(bus.first_fail_address), 32'(0));
    chk({tag, "_ffd"}, 32'(bus.first_fail_data), 32'(0));
    chk({tag, "_wren"}, 32'(bus.ram_wren), 32'(0));
  endtask

  // Issue one start pulse; expected result is queued before the accepting edge.
  task automatic sweep(input logic [1:0] m, input logic [7:0] pat, input logic [7:0] pat_after,
                       input int err, input int ps, input int fv, input int ffa, input int ffd);
    exp_t e;
    @(negedge clock);
    e.err = err; e.pass = ps; e.fv = fv; e.ffa = ffa; e.ffd = ffd;
    e.done_cyc = cyc + 18;
    q.push_back(e);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.pattern = pat;
    @(negedge clock);
    bus.start   = 1'b0;
    bus.pattern = pat_after;
    bus.mode    = ~m;
    chk("busy_after_start", 32'(bus.busy), 32'(1));
  endtask

  task automatic wait_empty(input string nm, input int lim);
    for (int i = 0; i < lim && q.size() != 0; i++) @(negedge clock);
    chk({nm, "_timeout"}, 32'(q.size()), 32'(0));
    repeat (2) @(negedge clock);
  endtask

  task automatic fill_inc();
    for (int a = 0; a < 16; a++) begin
      logic [3:0] a4;
      a4 = 4'(a);
      mem[a] = {~a4, a4};
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int a = 0; a < 16; a++) mem[a] = v;
  endtask

  initial begin : stim
    exp_t e;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.pattern = 8'h00;
    fill_const(8'h00);
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    clear = 1'b0;

    // {~a,a} image, mode 11
    fill_inc();
    sweep(2'b11, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    wait_empty("inc", 40);

    // all FF except two bad words, mode 10
    fill_const(8'hFF);
    mem[5] = 8'hF7;
    mem[9] = 8'h00;
    sweep(2'b10, 8'h00, 8'h00, 2, 0, 1, 5, 8'hF7);
    wait_empty("ff2", 40);

    // latched pattern A5, input pattern changed after start
    fill_const(8'hA5);
    sweep(2'b00, 8'hA5, 8'h00, 0, 1, 0, 5, 8'hF7);
    wait_empty("pat", 40);

    // all words wrong
    fill_const(8'h00);
    sweep(2'b10, 8'h00, 8'h00, 16, 0, 1, 0, 0);
    wait_empty("all", 40);

    // clear in the middle of a sweep
    fill_const(8'h00);
    @(negedge clock);
    bus.start = 1'b1;
    bus.mode = 2'b10;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 30 && bus.ram_address != 4'd7; i++) @(negedge clock);
    chk("reach_addr7", 32'(bus.ram_address), 32'(7));
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check_reset_outputs("midclear");
    sweep(2'b01, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    wait_empty("after_clear", 40);

    // start held high: exactly two back-to-back sweeps, one idle cycle apart
    fill_inc();
    @(negedge clock);
    e.err = 0; e.pass = 1; e.fv = 0; e.ffa = 0; e.ffd = 0;
    e.done_cyc = cyc + 18;
    q.push_back(e);
    e.done_cyc = cyc + 37;
    q.push_back(e);
    bus.start = 1'b1;
    bus.mode  = 2'b11;
    for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clock);
    bus.start = 1'b0;
    chk("held_timeout", 32'(q.size()), 32'(0));
    repeat (3) @(negedge clock);
    chk("no_third_sweep", 32'(bus.busy), 32'(0));

    chk("ram_wren_never_high", 32'(wren_seen), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
